// File: rtl/lc3_mem_arbiter.sv
// Shares one request/ack memory port between LC3 instruction fetch and data access.
// Data wins ties; after MAX_STREAK data grants against a waiting fetch, the fetch is served.
module lc3_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instrmem_rd,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_instr,
  input  logic              data_req,
  input  logic              Data_rd,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err,
  output logic [1:0]        busy_owner
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam int TIMER_W  = $clog2(TIMEOUT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  // Encoding doubles as the busy_owner code.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    I_BUSY = 2'b01,
    D_BUSY = 2'b10
  } stateT;

  stateT               state, stateNext;
  logic [STREAK_W-1:0] streak, streakNext;
  logic [TIMER_W-1:0]  timer, timerNext;
  logic                memReqNext, memWeNext;
  logic [ADDR_W-1:0]   memAddrNext;
  logic [DATA_W-1:0]   memWdataNext, instrDoutNext, dataDoutNext;
  logic                completeInstrNext, completeDataNext, busErrNext;
  logic                instrPend, dataPend;

  // A request whose completion is showing this cycle is already consumed.
  assign instrPend = instrmem_rd & ~complete_instr;
  assign dataPend  = data_req & ~complete_data;

  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    stateNext         = state;
    streakNext        = streak;
    timerNext         = timer;
    memReqNext        = mem_req;
    memWeNext         = mem_we;
    memAddrNext       = mem_addr;
    memWdataNext      = mem_wdata;
    instrDoutNext     = Instr_dout;
    dataDoutNext      = Data_dout;
    completeInstrNext = 1'b0;
    completeDataNext  = 1'b0;
    busErrNext        = 1'b0;

    unique case (state)
      IDLE: begin
        if (dataPend && !(instrPend && streak == STREAK_MAX)) begin
          stateNext    = D_BUSY;
          memReqNext   = 1'b1;
          memWeNext    = ~Data_rd;
          memAddrNext  = Data_addr;
          memWdataNext = Data_din;
          timerNext    = '0;
          if (!instrPend) begin
            streakNext = '0;
          end else if (streak != STREAK_MAX) begin
            streakNext = streak + 1'b1;
          end
        end else if (instrPend) begin
          stateNext   = I_BUSY;
          memReqNext  = 1'b1;
          memWeNext   = 1'b0;
          memAddrNext = pc;
          timerNext   = '0;
          streakNext  = '0;
        end
      end

      I_BUSY, D_BUSY: begin
        // An ack on the last allowed cycle still counts as a normal completion.
        if (mem_ack || timer == TIMER_LAST) begin
          stateNext  = IDLE;
          memReqNext = 1'b0;
          timerNext  = '0;
          busErrNext = ~mem_ack;
          if (state == I_BUSY) begin
            completeInstrNext = 1'b1;
            instrDoutNext     = mem_ack ? mem_rdata : '0;
          end else begin
            completeDataNext = 1'b1;
            if (!mem_we) begin
              dataDoutNext = mem_ack ? mem_rdata : '0;
            end
          end
        end else begin
          timerNext = timer + 1'b1;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (reset) begin
      state          <= IDLE;
      streak         <= '0;
      timer          <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      Instr_dout     <= '0;
      Data_dout      <= '0;
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      bus_err        <= 1'b0;
      busy_owner     <= 2'b00;
    end else begin
      state          <= stateNext;
      streak         <= streakNext;
      timer          <= timerNext;
      mem_req        <= memReqNext;
      mem_we         <= memWeNext;
      mem_addr       <= memAddrNext;
      mem_wdata      <= memWdataNext;
      Instr_dout     <= instrDoutNext;
      Data_dout      <= dataDoutNext;
      complete_instr <= completeInstrNext;
      complete_data  <= completeDataNext;
      bus_err        <= busErrNext;
      busy_owner     <= stateNext;
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed scenarios plus randomized traffic for lc3_mem_arbiter, checked against a
// transaction-level arbitration model and a behavioural memory with configurable wait states.
module tb_lc3_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        instrmem_rd;
  logic [15:0] pc;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        data_req;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;
  logic [1:0]  busy_owner;

  // Memory responder controls (written only by the main sequence).
  logic        memEnable;
  logic        memRandom;
  int          memWaitCfg;
  int          staleTrig;

  logic [15:0] memArr [0:65535];

  int errors = 0;
  int checks = 0;

  lc3_mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .MAX_STREAK(4), .TIMEOUT(255)
  ) dut (
    .clock(clock), .reset(reset),
    .instrmem_rd(instrmem_rd), .pc(pc), .Instr_dout(Instr_dout), .complete_instr(complete_instr),
    .data_req(data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Data_dout(Data_dout), .complete_data(complete_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err), .busy_owner(busy_owner)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Behavioural memory: waits the configured (or random) number of cycles, then acks for one cycle.
  initial begin
    int waitLeft;
    bit inTxn;
    int staleSeen;
    waitLeft  = 0;
    inTxn     = 1'b0;
    staleSeen = 0;
    for (int i = 0; i < 65536; i++) memArr[i] = 16'(i) ^ 16'hC3A5;
    memArr[16'h3000] = 16'h1234;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      mem_ack = 1'b0;
      if (staleTrig != staleSeen) begin
        staleSeen = staleTrig;
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
      end else if (mem_req && memEnable) begin
        if (!inTxn) begin
          inTxn    = 1'b1;
          waitLeft = memRandom ? int'($urandom_range(3, 0)) : memWaitCfg;
        end
        if (waitLeft == 0) begin
          mem_ack = 1'b1;
          inTxn   = 1'b0;
          if (mem_we) begin
            memArr[mem_addr] = mem_wdata;
            mem_rdata        = 16'($urandom);
          end else begin
            mem_rdata = memArr[mem_addr];
          end
        end else begin
          waitLeft--;
        end
      end else if (!mem_req) begin
        inTxn = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cycles;
    logic        prevReq;
    logic [15:0] expData, expInstr, lastDataExp;
    logic [1:0]  grantLog [$];
    logic [1:0]  starvePat [11];
    // Transaction-level arbitration model.
    int          mOwner, mStreak;
    bit          mCompI, mCompD, mWe, iPend, dPend, nCompI, nCompD;
    logic [15:0] mAddr, mWdata, mInstrDout, mDataDout;

    starvePat = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    reset = 1'b1; instrmem_rd = 1'b0; pc = '0; data_req = 1'b0; Data_rd = 1'b1;
    Data_addr = '0; Data_din = '0;
    memEnable = 1'b1; memRandom = 1'b0; memWaitCfg = 0; staleTrig = 0;
    repeat (3) tick();

    // Reset state
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset completes", 32'({complete_instr, complete_data, bus_err}), 32'd0);
    check("reset busy_owner", 32'(busy_owner), 32'd0);
    check("reset douts", 32'({Instr_dout, Data_dout}), 32'd0);
    check("reset mem bus", 32'({mem_we, mem_addr}), 32'd0);
    reset = 1'b0;
    tick();

    // 1: single zero-wait fetch
    memWaitCfg = 0;
    instrmem_rd = 1'b1; pc = 16'h3000;
    tick();
    check("t1 mem_req", 32'(mem_req), 32'd1);
    check("t1 mem_addr", 32'(mem_addr), 32'h3000);
    check("t1 mem_we", 32'(mem_we), 32'd0);
    check("t1 owner", 32'(busy_owner), 32'd1);
    check("t1 early complete", 32'(complete_instr), 32'd0);
    tick();
    check("t1 complete_instr", 32'(complete_instr), 32'd1);
    check("t1 Instr_dout", 32'(Instr_dout), 32'h1234);
    check("t1 owner idle", 32'(busy_owner), 32'd0);
    check("t1 mem_req drop", 32'(mem_req), 32'd0);
    instrmem_rd = 1'b0;
    tick();
    check("t1 pulse width", 32'(complete_instr), 32'd0);
    check("t1 no regrant", 32'(mem_req), 32'd0);

    // 2: simultaneous requests, one wait state
    memWaitCfg = 1;
    expData  = memArr[16'h4000];
    expInstr = memArr[16'h3002];
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4000;
    instrmem_rd = 1'b1; pc = 16'h3002;
    tick();
    check("t2 data first owner", 32'(busy_owner), 32'd2);
    check("t2 data addr", 32'(mem_addr), 32'h4000);
    check("t2 data we", 32'(mem_we), 32'd0);
    tick();
    check("t2 req held", 32'(mem_req), 32'd1);
    check("t2 no early complete", 32'(complete_data), 32'd0);
    tick();
    check("t2 complete_data", 32'(complete_data), 32'd1);
    check("t2 Data_dout", 32'(Data_dout), 32'(expData));
    check("t2 idle gap", 32'(mem_req), 32'd0);
    data_req = 1'b0;
    tick();
    check("t2 fetch req", 32'(mem_req), 32'd1);
    check("t2 fetch addr", 32'(mem_addr), 32'h3002);
    check("t2 fetch owner", 32'(busy_owner), 32'd1);
    tick();
    tick();
    check("t2 complete_instr", 32'(complete_instr), 32'd1);
    check("t2 Instr_dout", 32'(Instr_dout), 32'(expInstr));
    instrmem_rd = 1'b0;
    tick();

    // 3: starvation guard; the fetch requester blinks while a data completion is showing
    memWaitCfg = 0;
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4100;
    instrmem_rd = 1'b1; pc = 16'h3004;
    lastDataExp = expData;
    prevReq = 1'b0;
    cycles = 0;
    while (grantLog.size() < 11 && cycles < 200) begin
      tick();
      cycles++;
      if (mem_req && !prevReq) begin
        grantLog.push_back(busy_owner);
        if (busy_owner == 2'd1) check("t3 fetch addr", 32'(mem_addr), 32'(pc));
      end
      prevReq = mem_req;
      if (complete_data) begin
        check("t3 read data", 32'(Data_dout), 32'(memArr[Data_addr]));
        lastDataExp = memArr[Data_addr];
        Data_addr   = Data_addr + 16'h1;
      end
      if (complete_instr) pc = pc + 16'h1;
      instrmem_rd = !complete_data;
    end
    check("t3 grant count", 32'(grantLog.size()), 32'd11);
    for (int i = 0; i < grantLog.size(); i++) check($sformatf("t3 grant %0d", i), 32'(grantLog[i]), 32'(starvePat[i]));
    // Requester drops during the final fetch; the completion must still arrive.
    data_req = 1'b0; instrmem_rd = 1'b0;
    tick();
    check("t3 complete after drop", 32'(complete_instr), 32'd1);
    tick();

    // 4: write with three wait states
    memWaitCfg = 3;
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h4010; Data_din = 16'hBEEF;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t4 mem_req", 32'(mem_req), 32'd1);
      check("t4 write bus", 32'({mem_we, mem_addr, mem_wdata}), {15'd0, 1'b1, 16'h4010} << 16 | 32'hBEEF);
      check("t4 no early complete", 32'(complete_data), 32'd0);
    end
    tick();
    check("t4 complete_data", 32'(complete_data), 32'd1);
    check("t4 Data_dout unchanged", 32'(Data_dout), 32'(lastDataExp));
    check("t4 mem_req drop", 32'(mem_req), 32'd0);
    data_req = 1'b0; Data_rd = 1'b1;
    tick();
    check("t4 single pulse", 32'(complete_data), 32'd0);
    check("t4 memory written", 32'(memArr[16'h4010]), 32'hBEEF);

    // 5: timeout on a fetch, then a stale ack in IDLE
    memEnable = 1'b0;
    instrmem_rd = 1'b1; pc = 16'h3200;
    tick();
    check("t5 grant", 32'({mem_req, busy_owner}), 32'b101);
    cycles = 0;
    while (!complete_instr && cycles < 300) begin
      tick();
      cycles++;
    end
    check("t5 timeout cycles", 32'(cycles), 32'd255);
    check("t5 bus_err", 32'(bus_err), 32'd1);
    check("t5 Instr_dout zero", 32'(Instr_dout), 32'd0);
    check("t5 mem_req drop", 32'(mem_req), 32'd0);
    instrmem_rd = 1'b0;
    memEnable = 1'b1;
    tick();
    check("t5 bus_err pulse", 32'({bus_err, complete_instr}), 32'd0);
    staleTrig++;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t5 stale ack ignored", 32'({complete_instr, complete_data, bus_err, busy_owner}), 32'd0);
    end

    // 6: reset in the middle of a five-wait read
    memWaitCfg = 5;
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4020;
    tick();
    check("t6 grant", 32'(mem_req), 32'd1);
    tick();
    reset = 1'b1; data_req = 1'b0;
    tick();
    reset = 1'b0;
    check("t6 mem_req after reset", 32'(mem_req), 32'd0);
    check("t6 outputs zero", 32'({Instr_dout, Data_dout}), 32'd0);
    check("t6 flags zero", 32'({complete_instr, complete_data, bus_err, busy_owner, mem_we}), 32'd0);
    staleTrig++;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t6 no completion", 32'({complete_data, complete_instr, mem_req}), 32'd0);
    end

    // Randomized traffic against the arbitration model
    reset = 1'b1; instrmem_rd = 1'b0; data_req = 1'b0;
    tick();
    reset = 1'b0;
    memRandom = 1'b1;
    mOwner = 0; mStreak = 0; mCompI = 1'b0; mCompD = 1'b0; mWe = 1'b0;
    mAddr = '0; mWdata = '0; mInstrDout = '0; mDataDout = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (mCompI || !instrmem_rd) begin
        instrmem_rd = ($urandom_range(1, 0) == 1);
        pc = 16'($urandom);
      end
      if (mCompD || !data_req) begin
        data_req  = ($urandom_range(1, 0) == 1);
        Data_rd   = ($urandom_range(2, 0) != 0);
        Data_addr = 16'h5000 | 16'($urandom_range(15, 0));
        Data_din  = 16'($urandom);
      end

      iPend = instrmem_rd && !mCompI;
      dPend = data_req && !mCompD;
      nCompI = 1'b0;
      nCompD = 1'b0;
      if (mOwner == 0) begin
        if (dPend && !(iPend && mStreak == 4)) begin
          mOwner = 2; mAddr = Data_addr; mWe = !Data_rd; mWdata = Data_din;
          mStreak = iPend ? ((mStreak < 4) ? mStreak + 1 : 4) : 0;
        end else if (iPend) begin
          mOwner = 1; mAddr = pc; mWe = 1'b0; mStreak = 0;
        end
      end else if (mem_ack) begin
        if (mOwner == 1) begin
          nCompI = 1'b1; mInstrDout = mem_rdata;
        end else begin
          nCompD = 1'b1;
          if (!mWe) mDataDout = mem_rdata;
        end
        mOwner = 0;
      end
      mCompI = nCompI;
      mCompD = nCompD;

      tick();
      check("rand owner", 32'(busy_owner), 32'(mOwner));
      check("rand mem_req", 32'(mem_req), 32'(mOwner != 0));
      check("rand completes", 32'({complete_instr, complete_data}), 32'({mCompI, mCompD}));
      if (mOwner != 0) begin
        check("rand mem_addr", 32'(mem_addr), 32'(mAddr));
        check("rand mem_we", 32'(mem_we), 32'(mWe));
        if (mWe) check("rand mem_wdata", 32'(mem_wdata), 32'(mWdata));
      end
      if (mCompI) check("rand Instr_dout", 32'(Instr_dout), 32'(mInstrDout));
      if (mCompD) check("rand Data_dout", 32'(Data_dout), 32'(mDataDout));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
Shares a single unified, variable-latency memory port between the LC3 Fetch stage (instruction reads) and the MemAccess stage (data reads and writes). The block sits between the LC3 core's instruction and data memory interfaces and one external memory, which presents a request/ack handshake. It produces the core-facing complete_instr / complete_data strobes. Data accesses have fixed priority, and a fairness counter prevents fetch starvation.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MAX_STREAK, 4, maximum consecutive data grants allowed while a fetch is pending
TIMEOUT, 255, memory cycles to wait for mem_ack before aborting (counter width = clog2(TIMEOUT+1))

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
instrmem_rd  in  1  fetch request, level, held until complete_instr
pc  in  ADDR_W  fetch address
Instr_dout  out  DATA_W  fetched instruction, valid while complete_instr=1
complete_instr  out  1  one-cycle fetch completion pulse
data_req  in  1  data request, level, held until complete_data
Data_rd  in  1  1 = read, 0 = write
Data_addr  in  ADDR_W  data address
Data_din  in  DATA_W  write data
Data_dout  out  DATA_W  read data, valid while complete_data=1
complete_data  out  1  one-cycle data completion pulse
mem_req  out  1  memory request, held until mem_ack or timeout
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one cycle
bus_err  out  1  one-cycle pulse, coincident with complete_* on timeout
busy_owner  out  2  00 idle, 01 instr, 10 data

Behaviour:
- Reset:
  - All outputs are 0, and state is IDLE.
  - streak and timeout counters are 0.
  - Instr_dout and Data_dout are 0.
- State machine:
  - States are IDLE, I_BUSY and D_BUSY. All outputs are registered.
  - IDLE: sample requests at the edge.
    - A request whose complete_* is high in the current cycle is masked, because that request is being consumed.
    - data_req only -> D_BUSY.
    - instrmem_rd only -> I_BUSY.
    - Both -> D_BUSY, unless streak == MAX_STREAK, in which case -> I_BUSY.
- Grant:
  - On entering a BUSY state, capture the address, write data and direction.
  - Drive mem_req=1 and mem_addr; mem_we = ~Data_rd (data grant) or 0 (instr grant).
  - busy_owner updates on the same edge.
- Streak counter:
  - Increments on a data grant made while instrmem_rd is pending (unmasked). It saturates at MAX_STREAK.
  - Clears on any instr grant.
  - Clears on a data grant made while no fetch is pending.
- Completion:
  - At the edge sampling mem_ack=1 in BUSY: go to IDLE and drop mem_req.
  - Pulse complete_instr or complete_data for exactly one cycle.
  - Load Instr_dout or Data_dout from mem_rdata. A write completion leaves Data_dout unchanged.
- Latency:
  - Request sampled at edge k -> mem_req high after edge k.
  - A zero-wait memory acks in that cycle -> complete high after edge k+1, so the minimum latency is 2 cycles.
  - Each memory wait cycle adds 1 cycle.
  - Minimum spacing between grants is 2 cycles: the IDLE cycle carries complete.
- Timeout:
  - The counter runs while in BUSY.
  - After TIMEOUT cycles without mem_ack: drop mem_req and go to IDLE.
  - Pulse complete_* and bus_err together; the read data output becomes 0.
  - A stale mem_ack arriving later is ignored.
- mem_ack in IDLE is ignored.
- Requester behaviour mid-transaction:
  - If a requester deasserts its request mid-transaction, the memory access still finishes and the complete pulse is still issued.
  - Inputs are not re-sampled during BUSY.
- Reset mid-transaction:
  - mem_req is 0 the cycle after the reset edge.
  - No completion pulse is issued for the aborted access.
- mem_addr, mem_wdata and mem_we hold their value while mem_req=1. They are don't-care when mem_req=0.

Test Plan:
1. Single fetch, zero-wait: instrmem_rd=1, pc=0x3000; memory acks with mem_rdata=0x1234 in the first mem_req cycle. Required: mem_addr=0x3000, mem_we=0, complete_instr pulses 2 cycles after the request, Instr_dout=0x1234, busy_owner returns to 00.
2. Simultaneous requests: data_req=1 (read 0x4000) and instrmem_rd=1 (pc 0x3002) in the same cycle, 1 wait state. Required: data is served first with mem_addr=0x4000, then fetch with mem_addr=0x3002, and there is exactly one IDLE cycle between the two mem_req windows.
3. Starvation guard: data_req held continuously with new addresses, instrmem_rd held. Required: exactly 4 data grants occur, then 1 instr grant, and the streak counter restarts.
4. Write: Data_rd=0, Data_addr=0x4010, Data_din=0xBEEF, 3 wait states. Required: mem_we=1 and mem_wdata=0xBEEF held for 4 cycles, complete_data pulses once, Data_dout is unchanged.
5. Timeout: fetch granted and mem_ack never asserted. Required: after 255 BUSY cycles, complete_instr=1 and bus_err=1 together with Instr_dout=0; a late mem_ack then produces no pulse.
6. Reset mid-operation: data read granted with 5 wait states, reset asserted for 1 cycle at wait cycle 2. Required: mem_req=0 the next cycle, the later mem_ack is ignored, no complete_data pulse occurs, and all outputs are 0.
